// File: rtl/interrupt_controller_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_controller_pkg
//   Shared definitions for the interrupt controller: the number of sources,
//   register offsets relative to BASE_ADDR, the request/retire FSM encoding
//   and the default parameter values.
// -----------------------------------------------------------------------------
package interrupt_controller_pkg;

    localparam int NUM_IRQ = 8;

    // Register offsets from BASE_ADDR (word addresses)
    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [15:0] NUM_REGS   = 16'd3;

    // Default parameter values
    localparam logic [15:0]        DEF_BASE_ADDR  = 16'hFF00;
    localparam logic [NUM_IRQ-1:0] DEF_EDGE_SRC   = 8'hFF;
    localparam logic [NUM_IRQ-1:0] DEF_MASK_RESET = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_RETIRE  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// -----------------------------------------------------------------------------
// irq_priority_encoder
//   Combinational lowest-set-bit encoder: source 0 has the highest priority.
//   Ports:
//     req        in   NUM_IRQ  eligible sources (pending & mask)
//     num        out  3        index of the lowest set bit (0 when none set)
//     any_valid  out  1        at least one bit of req is set
// -----------------------------------------------------------------------------
module irq_priority_encoder
    import interrupt_controller_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [2:0]         num,
    output logic               any_valid
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        num       = 3'd0;
        any_valid = |req;
        // Scan from the top down so the lowest set index is written last.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                num = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//   Latches 8 peripheral interrupt lines as pending, gates them with a mask and
//   presents one prioritised request (interrupt_en/interrupt_num) to the control
//   unit. The request is retired on the rising edge of interrupt_ack, and no new
//   request is raised until interrupt_ack has fallen again. MASK, PENDING and
//   STATUS are memory-mapped at BASE_ADDR+0/+1/+2.
//   Ports:
//     clk            in   1   system clock
//     rst            in   1   synchronous active-high reset
//     irq_lines      in   8   peripheral requests (synchronous to clk)
//     bus_address    in   16  CPU word address
//     bus_data_in    in   16  CPU write data
//     bus_read_en    in   1   read strobe
//     bus_write_en   in   1   write strobe
//     bus_data_out   out  16  read data, valid the cycle after a hit read
//     bus_hit        out  1   previous read strobe addressed this block
//     interrupt_en   out  1   request to the control unit
//     interrupt_num  out  3   source requested / in service
//     interrupt_ack  in   1   acknowledge level from the control unit
// -----------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [15:0]        BASE_ADDR  = DEF_BASE_ADDR,
    parameter logic [NUM_IRQ-1:0] EDGE_SRC   = DEF_EDGE_SRC,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = DEF_MASK_RESET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic [15:0]        bus_address,
    input  logic [15:0]        bus_data_in,
    input  logic               bus_read_en,
    input  logic               bus_write_en,
    output logic [15:0]        bus_data_out,
    output logic               bus_hit,
    output logic               interrupt_en,
    output logic [2:0]         interrupt_num,
    input  logic               interrupt_ack
);

    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] prev_lines;
    logic [NUM_IRQ-1:0] capture_set;
    logic [NUM_IRQ-1:0] w1c_clear;
    logic [NUM_IRQ-1:0] retire_clear;
    logic [NUM_IRQ-1:0] eligible;
    logic               ack_prev;
    logic               ack_rise;
    state_t             state;
    state_t             state_next;
    logic               en_next;
    logic [2:0]         num_next;
    logic [2:0]         enc_num;
    logic               enc_valid;
    logic [15:0]        offset;
    logic               addr_hit;
    logic [1:0]         reg_sel;
    logic [15:0]        read_mux;
    logic               unused_data_bits;

    // Only the low byte of write data is meaningful for these registers.
    assign unused_data_bits = ^bus_data_in[15:8];

    // ---------------- bus decode ----------------
    // The 16-bit subtraction wraps addresses below BASE_ADDR to large values,
    // so one compare covers both ends of the window.
    assign offset   = bus_address - BASE_ADDR;
    assign addr_hit = (offset < NUM_REGS);
    assign reg_sel  = offset[1:0];

    always_comb begin
        read_mux = 16'h0000;
        case (reg_sel)
            REG_MASK:    read_mux = {8'h00, mask};
            REG_PENDING: read_mux = {8'h00, pending};
            REG_STATUS:  read_mux = {11'b0, state == ST_REQUEST, interrupt_en, interrupt_num};
            default:     read_mux = 16'h0000;
        endcase
    end

    // ---------------- capture / pending ----------------
    assign capture_set = (EDGE_SRC & irq_lines & ~prev_lines) | (~EDGE_SRC & irq_lines);
    assign w1c_clear   = (bus_write_en && addr_hit && reg_sel == REG_PENDING)
                         ? bus_data_in[NUM_IRQ-1:0] : '0;
    // A new capture wins over a W1C or retire clear in the same cycle.
    assign pending_next = (pending & ~(w1c_clear | retire_clear)) | capture_set;
    assign eligible     = pending & mask;
    assign ack_rise     = interrupt_ack & ~ack_prev;

    irq_priority_encoder u_encoder (
        .req       (eligible),
        .num       (enc_num),
        .any_valid (enc_valid)
    );

    // ---------------- request FSM ----------------
    always_comb begin
        state_next   = state;
        en_next      = interrupt_en;
        num_next     = interrupt_num;
        retire_clear = '0;
        case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_next = ST_REQUEST;
                    en_next    = 1'b1;
                    num_next   = enc_num;
                end
            end
            ST_REQUEST: begin
                // Masking or W1C of the in-service source does not withdraw the
                // request: the CPU may already be vectoring to it.
                if (ack_rise) begin
                    retire_clear = NUM_IRQ'(1) << interrupt_num;
                    en_next      = 1'b0;
                    state_next   = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                // One retire per ack pulse; wait for the CPU to drop ack.
                if (!interrupt_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                en_next    = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            interrupt_en  <= 1'b0;
            interrupt_num <= 3'd0;
            mask          <= MASK_RESET;
            pending       <= '0;
            prev_lines    <= '0;
            ack_prev      <= 1'b0;
            bus_data_out  <= 16'h0000;
            bus_hit       <= 1'b0;
        end else begin
            state         <= state_next;
            interrupt_en  <= en_next;
            interrupt_num <= num_next;
            pending       <= pending_next;
            prev_lines    <= irq_lines;
            ack_prev      <= interrupt_ack;
            bus_hit       <= bus_read_en & addr_hit;
            if (bus_write_en && addr_hit && reg_sel == REG_MASK) begin
                mask <= bus_data_in[NUM_IRQ-1:0];
            end
            // read_mux sees the pre-write register values, so a same-cycle
            // read+write returns the old contents.
            if (bus_read_en && addr_hit) begin
                bus_data_out <= read_mux;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//   Directed stimulus with a scoreboard: expected read data and expected
//   interrupt numbers are queued by the stimulus; a negedge monitor pops and
//   compares whenever bus_hit is high or interrupt_en rises.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    localparam logic [15:0] BASE    = 16'hFF00;
    localparam logic [15:0] A_MASK  = BASE + 16'd0;
    localparam logic [15:0] A_PEND  = BASE + 16'd1;
    localparam logic [15:0] A_STAT  = BASE + 16'd2;

    typedef struct {
        string       name;
        logic [15:0] value;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_lines;
    logic [15:0] bus_address;
    logic [15:0] bus_data_in;
    logic        bus_read_en;
    logic        bus_write_en;
    logic [15:0] bus_data_out;
    logic        bus_hit;
    logic        interrupt_en;
    logic [2:0]  interrupt_num;
    logic        interrupt_ack;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t rd_q[$];
    exp_t req_q[$];
    logic en_seen = 1'b0;
    exp_t mon_exp;

    interrupt_controller dut (
        .clk           (clk),
        .rst           (rst),
        .irq_lines     (irq_lines),
        .bus_address   (bus_address),
        .bus_data_in   (bus_data_in),
        .bus_read_en   (bus_read_en),
        .bus_write_en  (bus_write_en),
        .bus_data_out  (bus_data_out),
        .bus_hit       (bus_hit),
        .interrupt_en  (interrupt_en),
        .interrupt_num (interrupt_num),
        .interrupt_ack (interrupt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Monitor: compares DUT-presented outputs against queued expectations.
    always @(negedge clk) begin
        if (bus_hit) begin
            if (rd_q.size() == 0) begin
                check("unexpected_bus_hit", 16'(bus_hit), 16'h0000);
            end else begin
                mon_exp = rd_q.pop_front();
                check(mon_exp.name, bus_data_out, mon_exp.value);
            end
        end
        if (interrupt_en && !en_seen) begin
            if (req_q.size() == 0) begin
                check("unexpected_request", 16'(interrupt_num), 16'hFFFF);
            end else begin
                mon_exp = req_q.pop_front();
                check(mon_exp.name, 16'(interrupt_num), mon_exp.value);
            end
        end
        en_seen <= interrupt_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input string name, input logic [15:0] value);
        exp_t e;
        e.name  = name;
        e.value = value;
        rd_q.push_back(e);
    endtask

    task automatic expect_req(input string name, input logic [2:0] num);
        exp_t e;
        e.name  = name;
        e.value = 16'(num);
        req_q.push_back(e);
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [15:0] value, input string name);
        expect_read(name, value);
        bus_address = addr;
        bus_read_en = 1'b1;
        tick(1);
        bus_read_en = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        bus_address  = addr;
        bus_data_in  = data;
        bus_write_en = 1'b1;
        tick(1);
        bus_write_en = 1'b0;
    endtask

    task automatic ack_pulse(input int cycles);
        interrupt_ack = 1'b1;
        tick(cycles);
        interrupt_ack = 1'b0;
        tick(1);
    endtask

    // Bounded wait on interrupt_en; an expired budget is a failed comparison.
    task automatic wait_en(input logic value, input int budget, input string name);
        for (int i = 0; i < budget && interrupt_en !== value; i++) begin
            tick(1);
        end
        check(name, 16'(interrupt_en), 16'(value));
    endtask

    initial begin
        rst           = 1'b1;
        irq_lines     = 8'h00;
        bus_address   = 16'h0000;
        bus_data_in   = 16'h0000;
        bus_read_en   = 1'b0;
        bus_write_en  = 1'b0;
        interrupt_ack = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_en",  16'(interrupt_en),  16'h0000);
        check("rst_num", 16'(interrupt_num), 16'h0000);
        check("rst_data", bus_data_out,      16'h0000);
        check("rst_hit", 16'(bus_hit),       16'h0000);
        bus_read(A_MASK, 16'h0000, "rst_mask");
        bus_read(A_PEND, 16'h0000, "rst_pending");
        bus_read(A_STAT, 16'h0000, "rst_status");

        // 1: single edge source, request latency and ack retire
        bus_write(A_MASK, 16'h0001);
        expect_req("t1_num", 3'd0);
        irq_lines = 8'h01;
        tick(1);
        check("t1_not_yet", 16'(interrupt_en), 16'h0000);
        irq_lines = 8'h00;
        tick(1);
        check("t1_request", 16'(interrupt_en), 16'h0001);
        bus_read(A_STAT, 16'h0018, "t1_status_req");
        interrupt_ack = 1'b1;
        tick(1);
        check("t1_ack_drop", 16'(interrupt_en), 16'h0000);
        tick(3);
        interrupt_ack = 1'b0;
        tick(1);
        bus_read(A_PEND, 16'h0000, "t1_pending_clr");

        // 2: two simultaneous sources, lowest index first
        bus_write(A_MASK, 16'h00FF);
        expect_req("t2_first_num", 3'd2);
        expect_req("t2_second_num", 3'd5);
        irq_lines = 8'h24;
        tick(1);
        irq_lines = 8'h00;
        wait_en(1'b1, 3, "t2_first_en");
        interrupt_ack = 1'b1;
        tick(1);
        check("t2_retire", 16'(interrupt_en), 16'h0000);
        bus_read(A_PEND, 16'h0020, "t2_pending_mid");
        interrupt_ack = 1'b0;
        tick(1);
        wait_en(1'b1, 3, "t2_second_en");
        ack_pulse(2);
        bus_read(A_PEND, 16'h0000, "t2_pending_end");

        // 3: masked source stays pending until unmasked
        bus_write(A_MASK, 16'h0000);
        irq_lines = 8'h08;
        tick(1);
        irq_lines = 8'h00;
        tick(2);
        check("t3_masked_no_req", 16'(interrupt_en), 16'h0000);
        bus_read(A_PEND, 16'h0008, "t3_pending");
        expect_req("t3_num", 3'd3);
        bus_write(A_MASK, 16'h0008);
        wait_en(1'b1, 2, "t3_unmask_req");
        ack_pulse(1);

        // 4: long ack with the same source re-pulsed: one retire only
        bus_write(A_MASK, 16'h0002);
        expect_req("t4_first_num", 3'd1);
        irq_lines = 8'h02;
        tick(1);
        irq_lines = 8'h00;
        wait_en(1'b1, 3, "t4_first_en");
        interrupt_ack = 1'b1;
        tick(1);
        check("t4_retire", 16'(interrupt_en), 16'h0000);
        irq_lines = 8'h02;
        tick(1);
        irq_lines = 8'h00;
        bus_read(A_PEND, 16'h0002, "t4_pending_during_ack");
        tick(3);
        check("t4_no_req_ack_high", 16'(interrupt_en), 16'h0000);
        interrupt_ack = 1'b0;
        expect_req("t4_second_num", 3'd1);
        tick(1);
        check("t4_wait_ack_low", 16'(interrupt_en), 16'h0000);
        wait_en(1'b1, 2, "t4_second_en");
        ack_pulse(2);

        // 5: W1C, capture beats clear, read-before-write, address miss
        bus_write(A_MASK, 16'h0000);
        irq_lines = 8'h06;
        tick(1);
        irq_lines = 8'h00;
        bus_read(A_PEND, 16'h0006, "t5_pending_06");
        bus_write(A_PEND, 16'h00FF);
        bus_read(A_PEND, 16'h0000, "t5_w1c_all");
        irq_lines = 8'h10;
        bus_write(A_PEND, 16'h0010);
        irq_lines = 8'h00;
        bus_read(A_PEND, 16'h0010, "t5_set_beats_clear");
        expect_read("t5_read_old_mask", 16'h0000);
        bus_address  = A_MASK;
        bus_data_in  = 16'h00A2;
        bus_read_en  = 1'b1;
        bus_write_en = 1'b1;
        tick(1);
        bus_read_en  = 1'b0;
        bus_write_en = 1'b0;
        bus_read(A_MASK, 16'h00A2, "t5_read_new_mask");
        bus_address = BASE + 16'd3;
        bus_read_en = 1'b1;
        tick(1);
        bus_read_en = 1'b0;
        check("t5_miss_hit", 16'(bus_hit), 16'h0000);
        check("t5_miss_hold", bus_data_out, 16'h00A2);

        // 6: reset while requesting
        expect_req("t6_num", 3'd4);
        bus_write(A_MASK, 16'h0010);
        wait_en(1'b1, 2, "t6_req_en");
        bus_read(A_STAT, 16'h001C, "t6_status_req");
        rst = 1'b1;
        tick(1);
        check("t6_rst_en",  16'(interrupt_en),  16'h0000);
        check("t6_rst_num", 16'(interrupt_num), 16'h0000);
        check("t6_rst_hit", 16'(bus_hit),       16'h0000);
        rst = 1'b0;
        bus_read(A_PEND, 16'h0000, "t6_pending");
        bus_read(A_MASK, 16'h0000, "t6_mask");
        bus_read(A_STAT, 16'h0000, "t6_status");
        tick(3);

        check("rd_queue_drained",  16'(rd_q.size()),  16'h0000);
        check("req_queue_drained", 16'(req_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
